// File: rtl/float_divider_bf16.sv
// Sequential bf16 divider, y = a / b, restoring mantissa division at one quotient bit per clock.
// An operation starts on reset release; operands must be held stable until is_output_valid.
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous, active-low clear; a fresh operation starts on release
//   a, b             dividend / divisor {sign, exponent, mantissa}
//   y                registered quotient, valid while is_output_valid is high
//   is_output_valid  high once y holds the final result, held until the next reset
module float_divider_bf16 #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MANT_WIDTH = 7,
    parameter int unsigned BIAS       = 127
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]   a,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]   b,
    output logic [EXP_WIDTH+MANT_WIDTH:0]   y,
    output logic                            is_output_valid
);

    localparam int unsigned W       = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int unsigned XW      = EXP_WIDTH + 2;
    localparam int unsigned QW      = MANT_WIDTH + 3;
    localparam int unsigned RW      = MANT_WIDTH + 2;
    localparam int unsigned CW      = $clog2(QW + 1);
    localparam int unsigned EXP_MAX = (1 << EXP_WIDTH) - 1;
    localparam logic [W-1:0] QNAN   = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_LOAD, S_DIVIDE, S_ROUND, S_DONE} state_t;

    state_t                  state, state_next;
    logic                    sign_q, sign_next;
    logic signed [XW-1:0]    exp_q, exp_next;
    logic [MANT_WIDTH:0]     div_q, div_next;
    logic [RW-1:0]           rem_q, rem_next;
    logic [QW-1:0]           quo_q, quo_next;
    logic [CW-1:0]           cnt_q, cnt_next;
    logic [W-1:0]            special_q, special_next;
    logic [W-1:0]            y_next;
    logic                    valid_next;

    // Operand fields and classification (subnormals count as zero)
    logic                    sa, sb;
    logic [EXP_WIDTH-1:0]    ea, eb;
    logic [MANT_WIDTH-1:0]   ma, mb;
    logic                    a_zero, b_zero, a_inf, b_inf, is_nan;

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (ma == '0);
    assign b_inf  = (&eb) && (mb == '0);
    assign is_nan = ((&ea) && (ma != '0)) || ((&eb) && (mb != '0)) ||
                    (a_zero && b_zero) || (a_inf && b_inf);

    // Datapath temporaries
    logic                    ge;
    logic [MANT_WIDTH:0]     trial, rem_sel;
    logic [MANT_WIDTH-1:0]   mant;
    logic                    guard, sticky;
    logic [MANT_WIDTH:0]     mant_sum;
    logic signed [XW-1:0]    exp_adj, exp_fin;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= S_LOAD;
            sign_q          <= 1'b0;
            exp_q           <= '0;
            div_q           <= '0;
            rem_q           <= '0;
            quo_q           <= '0;
            cnt_q           <= '0;
            special_q       <= '0;
            y               <= '0;
            is_output_valid <= 1'b0;
        end else begin
            state           <= state_next;
            sign_q          <= sign_next;
            exp_q           <= exp_next;
            div_q           <= div_next;
            rem_q           <= rem_next;
            quo_q           <= quo_next;
            cnt_q           <= cnt_next;
            special_q       <= special_next;
            y               <= y_next;
            is_output_valid <= valid_next;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_next   = state;
        sign_next    = sign_q;
        exp_next     = exp_q;
        div_next     = div_q;
        rem_next     = rem_q;
        quo_next     = quo_q;
        cnt_next     = cnt_q;
        special_next = special_q;
        y_next       = y;
        valid_next   = is_output_valid;
        ge           = 1'b0;
        trial        = '0;
        rem_sel      = '0;
        mant         = '0;
        guard        = 1'b0;
        sticky       = 1'b0;
        mant_sum     = '0;
        exp_adj      = '0;
        exp_fin      = '0;

        case (state)
            S_LOAD: begin
                sign_next = sa ^ sb;
                exp_next  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(XW'(BIAS));
                div_next  = {1'b1, mb};
                rem_next  = RW'({1'b1, ma});
                quo_next  = '0;
                cnt_next  = '0;
                if (is_nan) begin
                    special_next = QNAN;
                    state_next   = S_DONE;
                end else if (b_zero || a_inf) begin
                    special_next = {sa ^ sb, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                    state_next   = S_DONE;
                end else if (a_zero || b_inf) begin
                    special_next = {sa ^ sb, {(W-1){1'b0}}};
                    state_next   = S_DONE;
                end else begin
                    state_next = S_DIVIDE;
                end
            end

            // One restoring step: remainder stays below the divisor, so the shift never overflows
            S_DIVIDE: begin
                ge       = (rem_q >= RW'(div_q));
                trial    = rem_q[RW-2:0] - div_q;
                rem_sel  = ge ? trial : rem_q[RW-2:0];
                rem_next = {rem_sel, 1'b0};
                quo_next = {quo_q[QW-2:0], ge};
                cnt_next = cnt_q + CW'(1);
                if (cnt_q == CW'(QW - 1)) begin
                    state_next = S_ROUND;
                end
            end

            // Normalize, round to nearest even, then saturate or flush
            S_ROUND: begin
                if (quo_q[QW-1]) begin
                    mant    = quo_q[QW-2:2];
                    guard   = quo_q[1];
                    sticky  = quo_q[0] || (rem_q != '0);
                    exp_adj = exp_q;
                end else begin
                    mant    = quo_q[QW-3:1];
                    guard   = quo_q[0];
                    sticky  = (rem_q != '0);
                    exp_adj = exp_q - XW'(1);
                end
                mant_sum = {1'b0, mant} + (MANT_WIDTH+1)'(guard && (sticky || mant[0]));
                exp_fin  = exp_adj + XW'(mant_sum[MANT_WIDTH]);
                if (!exp_fin[XW-1] && (exp_fin[XW-2:0] >= (XW-1)'(EXP_MAX))) begin
                    y_next = {sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                end else if (exp_fin[XW-1] || (exp_fin == '0)) begin
                    y_next = {sign_q, {(W-1){1'b0}}};
                end else begin
                    y_next = {sign_q, exp_fin[EXP_WIDTH-1:0], mant_sum[MANT_WIDTH-1:0]};
                end
                valid_next = 1'b1;
                state_next = S_DONE;
            end

            // Special results surface one edge after LOAD; afterwards hold everything
            S_DONE: begin
                if (!is_output_valid) begin
                    y_next     = special_q;
                    valid_next = 1'b1;
                end
            end

            default: state_next = S_LOAD;
        endcase
    end

endmodule

// File: tb/tb_float_divider_bf16.sv
// Bench for float_divider_bf16: scoreboard of expected quotients, scenario tasks with inline checks.
module tb_float_divider_bf16;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        is_output_valid;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sb_q[$];

    always #5 clock = ~clock;

    float_divider_bf16 dut (
        .clock           (clock),
        .reset           (reset),
        .a               (a),
        .b               (b),
        .y               (y),
        .is_output_valid (is_output_valid)
    );

    // Hold reset for one cycle with new operands, release, and record the expected quotient
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [15:0] ey);
        @(negedge clock);
        reset = 1'b0;
        a     = ta;
        b     = tb_v;
        @(negedge clock);
        reset = 1'b1;
        sb_q.push_back(ey);
    endtask

    // Count edges after release until valid; edges = 0 means the budget expired
    task automatic wait_valid(output int edges, output logic [15:0] got);
        edges = 0;
        got   = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (is_output_valid) begin
                edges = i;
                got   = y;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_cmp++;
        if (y !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_y: got %h want 0000", y);
        end
        n_cmp++;
        if (is_output_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", is_output_valid);
        end
    endtask

    task automatic test_normal();
        logic [15:0] ta [3];
        logic [15:0] tv [3];
        logic [15:0] te [3];
        logic [15:0] got;
        logic [15:0] ey;
        int          lat;
        ta = '{16'h4040, 16'h3F80, 16'h3F80};
        tv = '{16'h4000, 16'hBF80, 16'h4040};
        te = '{16'h3FC0, 16'hBF80, 16'h3EAB};
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tv[i], te[i]);
            wait_valid(lat, got);
            ey = sb_q.pop_front();
            n_cmp++;
            if (lat !== 12) begin
                n_bad++;
                $display("FAIL normal_latency[%0d]: got %0d want 12", i, lat);
            end
            n_cmp++;
            if (got !== ey) begin
                n_bad++;
                $display("FAIL normal_y[%0d]: got %h want %h", i, got, ey);
            end
        end
    endtask

    task automatic test_special();
        logic [15:0] ta [4];
        logic [15:0] tv [4];
        logic [15:0] te [4];
        logic [15:0] got;
        logic [15:0] ey;
        int          lat;
        ta = '{16'h4000, 16'hC000, 16'h0000, 16'h0000};
        tv = '{16'h0000, 16'h0000, 16'h0000, 16'h4000};
        te = '{16'h7F80, 16'hFF80, 16'h7FC0, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tv[i], te[i]);
            wait_valid(lat, got);
            ey = sb_q.pop_front();
            n_cmp++;
            if (lat !== 2) begin
                n_bad++;
                $display("FAIL special_latency[%0d]: got %0d want 2", i, lat);
            end
            n_cmp++;
            if (got !== ey) begin
                n_bad++;
                $display("FAIL special_y[%0d]: got %h want %h", i, got, ey);
            end
        end
    endtask

    task automatic test_range();
        logic [15:0] ta [3];
        logic [15:0] tv [3];
        logic [15:0] te [3];
        int          tl [3];
        logic [15:0] got;
        logic [15:0] ey;
        int          lat;
        ta = '{16'h7F00, 16'h8080, 16'h0001};
        tv = '{16'h3E80, 16'h4000, 16'h3F80};
        te = '{16'h7F80, 16'h8000, 16'h0000};
        tl = '{12, 12, 2};
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tv[i], te[i]);
            wait_valid(lat, got);
            ey = sb_q.pop_front();
            n_cmp++;
            if (lat !== tl[i]) begin
                n_bad++;
                $display("FAIL range_latency[%0d]: got %0d want %0d", i, lat, tl[i]);
            end
            n_cmp++;
            if (got !== ey) begin
                n_bad++;
                $display("FAIL range_y[%0d]: got %h want %h", i, got, ey);
            end
        end
    endtask

    task automatic test_reset_mid_and_hold();
        logic [15:0] got;
        logic [15:0] ey;
        int          lat;
        start_op(16'h4040, 16'h4000, 16'h3FC0);
        repeat (5) @(posedge clock);
        #1;
        n_cmp++;
        if (is_output_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_valid_before_abort: got %b want 0", is_output_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        void'(sb_q.pop_back());
        n_cmp++;
        if (y !== 16'h0000) begin
            n_bad++;
            $display("FAIL mid_async_y: got %h want 0000", y);
        end
        n_cmp++;
        if (is_output_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_async_valid: got %b want 0", is_output_valid);
        end

        start_op(16'hBF40, 16'h3FE0, 16'hBEDB);
        wait_valid(lat, got);
        ey = sb_q.pop_front();
        n_cmp++;
        if (lat !== 12) begin
            n_bad++;
            $display("FAIL restart_latency: got %0d want 12", lat);
        end
        n_cmp++;
        if (got !== ey) begin
            n_bad++;
            $display("FAIL restart_y: got %h want %h", got, ey);
        end

        @(negedge clock);
        a = 16'h4040;
        b = 16'h4000;
        repeat (6) @(posedge clock);
        #1;
        n_cmp++;
        if (y !== ey) begin
            n_bad++;
            $display("FAIL hold_y: got %h want %h", y, ey);
        end
        n_cmp++;
        if (is_output_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_valid: got %b want 1", is_output_valid);
        end
    endtask

    initial begin
        reset = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clock);
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_reset_mid_and_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/float_divider_bf16.md
Name: float_divider_bf16

Overview:
- Sequential bf16 floating-point divider computing y = a / b. It is the inverse operation of float_multiplier_bf16 and the next arithmetic block in the same family.
- Mantissa quotient is produced by an iterative restoring divider, one quotient bit per clock.
- Same operation protocol as the multipliers: operands are held stable, an operation starts on reset release, and the result is flagged by is_output_valid.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- MANT_WIDTH, 7, stored mantissa field width (hidden bit implicit).
- BIAS, 127, exponent bias.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; reset=0 clears all state immediately.
- a  input  1+EXP_WIDTH+MANT_WIDTH  dividend; held stable from reset release until valid.
- b  input  1+EXP_WIDTH+MANT_WIDTH  divisor; same stability rule as a.
- y  output  1+EXP_WIDTH+MANT_WIDTH  quotient; registered.
- is_output_valid  output  1  high while y holds the final result.

Behaviour:
- Reset (reset=0, async):
  - y=0, is_output_valid=0.
  - State goes to LOAD; quotient, remainder and counter are cleared.
- States: LOAD -> DIVIDE -> ROUND -> DONE. Special cases go LOAD -> DONE directly.
- LOAD (1st rising edge after reset=1):
  - Sign = a.sign ^ b.sign.
  - Exponent = ea - eb + BIAS, computed in EXP_WIDTH+2 signed bits.
  - Divisor = {1,mb}; remainder = {1,ma}.
  - Special-case classification:
    - Subnormal inputs (exp=0) are treated as zero.
    - Either operand NaN, 0/0, or inf/inf: y=0x7FC0 (canonical NaN, sign 0).
    - b zero or a inf: y = {sign, all-ones, 0}.
    - a zero or b inf: y = {sign, 0}.
  - Special results go to DONE, with valid after the 2nd edge.
- DIVIDE: MANT_WIDTH+3 iterations (10 for bf16), one per edge.
  - Each iteration: trial = rem - divisor; if trial >= 0, set q bit = 1 and rem = trial, else q bit = 0. Then rem <<= 1.
  - Q holds 1 integer bit and MANT_WIDTH+2 fraction bits.
- ROUND (1 edge):
  - If Q[msb]=1: mantissa = Q[msb-1:2], guard = Q[1], sticky = Q[0] | (rem != 0).
  - Else: mantissa = Q[msb-2:1], guard = Q[0], sticky = (rem != 0), and exponent -= 1.
  - Round-to-nearest-even: increment when guard & (sticky | lsb). Mantissa carry-out sets exponent += 1 and mantissa = 0.
  - Final exponent >= all-ones: y = ±inf.
  - Final exponent <= 0: y = ±0 (flush to zero, sign kept).
- Latency:
  - Normal operands: is_output_valid rises after edge MANT_WIDTH+5 (12 for bf16).
  - Special cases: after edge 2.
- DONE: y and is_output_valid are held indefinitely. Operand changes are ignored until the next reset pulse.
- Reset mid-operation: async clear to reset values; no partial result is visible. A fresh operation starts on release.
- Operands changing before valid: the result is undefined; no protection is provided.

Test Plan:
- a=0x4040 (3.0), b=0x4000 (2.0) -> y=0x3FC0, valid after edge 12, valid=0 on edges 1..11.
- a=0x3F80, b=0xBF80 -> y=0xBF80. a=0x3F80, b=0x4040 -> y=0x3EAB (round-up path, sticky set).
- Specials, valid after edge 2: a=0x4000, b=0x0000 -> y=0x7F80. a=0xC000, b=0x0000 -> y=0xFF80. a=0x0000, b=0x0000 -> y=0x7FC0. a=0x0000, b=0x4000 -> y=0x0000.
- Range limits: a=0x7F00, b=0x3E80 -> y=0x7F80 (overflow). a=0x8080, b=0x4000 -> y=0x8000 (underflow, sign kept). a=0x0001 (subnormal), b=0x3F80 -> y=0x0000.
- Reset mid-operation: start a=0x4040, b=0x4000; drive reset=0 between edges 5 and 6 -> y=0 and valid=0 immediately (asynchronously). Release with a=0xBF40, b=0x3FE0 -> y=0xBEDB, valid after edge 12 from release.
- Hold: after valid, change a and b -> y and valid unchanged until the next reset pulse.
